// File: rtl/lcd_driver.sv
// HD44780-style LCD write sequencer driven by a single 32-bit IO register.
// A START toggle launches one write: setup, enable pulse, hold, then a
// command-dependent execution wait. All timing comes from one down-counter.
module lcd_driver #(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_EN    = 12,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_EXEC  = 2000,
    parameter int unsigned T_CLEAR = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_reg,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data,
    output logic [31:0] o_lcd_status
);

    // Counter is reloaded with (duration - 1), so it must hold the largest duration minus one.
    localparam int unsigned T_MAX_A = (T_SETUP > T_EN)    ? T_SETUP : T_EN;
    localparam int unsigned T_MAX_B = (T_HOLD  > T_EXEC)  ? T_HOLD  : T_EXEC;
    localparam int unsigned T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int unsigned T_MAX   = (T_MAX_C > T_CLEAR) ? T_MAX_C : T_CLEAR;
    localparam int unsigned CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_EXEC
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               start_q;
    logic               ovr_q;
    logic               busy_q;

    logic               on_in;
    logic               start_in;
    logic               req;
    logic               cnt_done;
    logic               slow_cmd;
    logic               unused_bits;

    // Decode of the IO register and of the latched command.
    assign on_in       = i_lcd_reg[31];
    assign start_in    = i_lcd_reg[30];
    assign req         = (start_in != start_q);
    assign cnt_done    = (cnt == '0);
    assign slow_cmd    = !o_lcd_rs &&
                         ((o_lcd_data == 8'h01) || (o_lcd_data == 8'h02) || (o_lcd_data == 8'h03));
    assign unused_bits = ^{i_lcd_reg[29:10], i_lcd_reg[8]};

    // Write-only interface; status exposes the sticky overrun and busy flops.
    assign o_lcd_rw     = 1'b0;
    assign o_lcd_status = {30'd0, ovr_q, busy_q};

    // Transaction sequencer: state, timing counter and all registered outputs.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            start_q    <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
            o_lcd_on   <= 1'b0;
            o_lcd_en   <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= 8'h00;
        end else begin
            start_q  <= start_in;
            o_lcd_on <= on_in;

            if ((state != S_IDLE) && !on_in) begin
                // Panel switched off mid-write: drop everything, no overrun.
                state    <= S_IDLE;
                cnt      <= '0;
                busy_q   <= 1'b0;
                o_lcd_en <= 1'b0;
            end else begin
                if ((state != S_IDLE) && req) begin
                    ovr_q <= 1'b1;
                end

                case (state)
                    S_IDLE: begin
                        if (req && on_in) begin
                            o_lcd_rs   <= i_lcd_reg[9];
                            o_lcd_data <= i_lcd_reg[7:0];
                            state      <= S_SETUP;
                            cnt        <= CNT_W'(T_SETUP - 1);
                            busy_q     <= 1'b1;
                        end
                    end

                    S_SETUP: begin
                        if (cnt_done) begin
                            state    <= S_PULSE;
                            cnt      <= CNT_W'(T_EN - 1);
                            o_lcd_en <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end

                    S_PULSE: begin
                        if (cnt_done) begin
                            state    <= S_HOLD;
                            cnt      <= CNT_W'(T_HOLD - 1);
                            o_lcd_en <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end

                    S_HOLD: begin
                        if (cnt_done) begin
                            state <= S_EXEC;
                            cnt   <= slow_cmd ? CNT_W'(T_CLEAR - 1) : CNT_W'(T_EXEC - 1);
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end

                    S_EXEC: begin
                        if (cnt_done) begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end

                    default: begin
                        state    <= S_IDLE;
                        cnt      <= '0;
                        busy_q   <= 1'b0;
                        o_lcd_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_driver.sv
// Bench for lcd_driver: directed vector table, hand-written corner sequences
// and a randomized phase, all compared each cycle against a timeline model.
module tb_lcd_driver;

    localparam int unsigned P_SETUP = 2;
    localparam int unsigned P_EN    = 12;
    localparam int unsigned P_HOLD  = 2;
    localparam int unsigned P_EXEC  = 40;
    localparam int unsigned P_CLEAR = 150;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] lcd_reg = 32'd0;
    logic        lcd_on, lcd_en, lcd_rs, lcd_rw;
    logic [7:0]  lcd_data;
    logic [31:0] lcd_status;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    lcd_driver #(
        .T_SETUP(P_SETUP),
        .T_EN   (P_EN),
        .T_HOLD (P_HOLD),
        .T_EXEC (P_EXEC),
        .T_CLEAR(P_CLEAR)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_lcd_reg   (lcd_reg),
        .o_lcd_on    (lcd_on),
        .o_lcd_en    (lcd_en),
        .o_lcd_rs    (lcd_rs),
        .o_lcd_rw    (lcd_rw),
        .o_lcd_data  (lcd_data),
        .o_lcd_status(lcd_status)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model: transaction timeline ----------------
    logic       m_on, m_rs, m_sq, m_ovr, m_active;
    logic [7:0] m_data;
    int         m_e, m_total;
    logic       m_en;

    function automatic bit is_slow(input logic rs, input logic [7:0] d);
        return !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_on <= 0; m_rs <= 0; m_sq <= 0; m_ovr <= 0; m_active <= 0;
            m_data <= 8'h00; m_e <= 0; m_total <= 0;
        end else begin
            m_sq <= lcd_reg[30];
            m_on <= lcd_reg[31];
            if (m_active && !lcd_reg[31]) begin
                m_active <= 0;
            end else if (m_active) begin
                if (lcd_reg[30] != m_sq) m_ovr <= 1;
                m_e <= m_e + 1;
                if (m_e + 1 > m_total) m_active <= 0;
            end else if ((lcd_reg[30] != m_sq) && lcd_reg[31]) begin
                m_active <= 1;
                m_e      <= 1;
                m_rs     <= lcd_reg[9];
                m_data   <= lcd_reg[7:0];
                m_total  <= int'(P_SETUP + P_EN + P_HOLD) +
                            (is_slow(lcd_reg[9], lcd_reg[7:0]) ? int'(P_CLEAR) : int'(P_EXEC));
            end
        end
    end

    assign m_en = m_active && (m_e > int'(P_SETUP)) && (m_e <= int'(P_SETUP + P_EN));

    logic [43:0] act_vec, exp_vec;
    assign act_vec = {lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data, lcd_status};
    assign exp_vec = {m_on, m_en, m_rs, 1'b0, m_data, 30'd0, m_ovr, m_active};

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("model", 64'(act_vec), 64'(exp_vec));
    endtask

    // Launch one write at the current negedge and follow it until idle.
    task automatic run_txn(input logic rs, input logic [7:0] data,
                           input int ovr_at, input int abort_at, input int snap_at,
                           output int en_first, output int en_last, output int busy_last,
                           output int pulses, output logic [43:0] snap,
                           output logic [7:0] data_at1, output logic rs_at1,
                           output bit timed_out);
        int c0, rel;
        logic prev_en;
        c0 = cyc;
        lcd_reg[30] = ~lcd_reg[30];
        lcd_reg[9] = rs;
        lcd_reg[7:0] = data;
        en_first = -1; en_last = -1; busy_last = 0; pulses = 0;
        snap = '0; data_at1 = 8'h00; rs_at1 = 1'b0; prev_en = 1'b0;
        timed_out = 1'b1;
        for (int k = 0; k < 400; k++) begin
            tick();
            rel = cyc - c0;
            if (lcd_en) begin
                if (en_first < 0) en_first = rel;
                en_last = rel;
                if (!prev_en) pulses++;
            end
            prev_en = lcd_en;
            if (rel == 1) begin data_at1 = lcd_data; rs_at1 = lcd_rs; end
            if (rel == snap_at) snap = act_vec;
            if (!lcd_status[0]) begin timed_out = 1'b0; break; end
            busy_last = rel;
            if (rel == ovr_at) lcd_reg[30] = ~lcd_reg[30];
            if (rel == abort_at) lcd_reg[31] = 1'b0;
        end
    endtask

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         exp_busy_last;
    } vec_t;

    vec_t tbl[8];

    int ef, el, bl, np;
    logic [43:0] sn;
    logic [7:0] d1;
    logic r1;
    bit to;
    int r;

    initial begin
        // busy last cycle = setup(2) + pulse(12) + hold(2) + exec wait
        tbl[0] = '{1'b0, 8'h38, 56};
        tbl[1] = '{1'b0, 8'h01, 166};
        tbl[2] = '{1'b0, 8'h02, 166};
        tbl[3] = '{1'b0, 8'h03, 166};
        tbl[4] = '{1'b1, 8'h41, 56};
        tbl[5] = '{1'b1, 8'h01, 56};
        tbl[6] = '{1'b0, 8'h04, 56};
        tbl[7] = '{1'b0, 8'h00, 56};

        // Reset with garbage on the register: everything must read zero.
        lcd_reg = 32'hFFFF_FFFF;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_state", 64'(act_vec), 64'd0);
        lcd_reg = 32'h8000_0000;
        rst_n = 1'b1;
        tick();
        tick();
        chk("on_follows", 64'(lcd_on), 64'd1);
        chk("idle_after_reset", 64'(lcd_status), 64'd0);

        // Directed table, transactions back-to-back.
        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i].rs, tbl[i].data, -1, -1, -1, ef, el, bl, np, sn, d1, r1, to);
            chk("tbl_timeout", 64'(to), 64'd0);
            chk("tbl_en_first", 64'(ef), 64'd3);
            chk("tbl_en_last", 64'(el), 64'd14);
            chk("tbl_busy_last", 64'(bl), 64'(tbl[i].exp_busy_last));
            chk("tbl_data", 64'(d1), 64'(tbl[i].data));
            chk("tbl_rs", 64'(r1), 64'(tbl[i].rs));
        end
        chk("tbl_rw", 64'(lcd_rw), 64'd0);

        // Overrun: second toggle in EXEC.
        run_txn(1'b0, 8'h38, 25, -1, 26, ef, el, bl, np, sn, d1, r1, to);
        chk("ovr_status", 64'(sn[31:0]), 64'h3);
        chk("ovr_data", 64'(sn[39:32]), 64'h38);
        chk("ovr_pulses", 64'(np), 64'd1);
        chk("ovr_busy_last", 64'(bl), 64'd56);
        chk("ovr_idle_status", 64'(lcd_status), 64'h2);

        // Abort: ON dropped during the enable pulse.
        run_txn(1'b0, 8'h38, -1, 8, 9, ef, el, bl, np, sn, d1, r1, to);
        chk("abort_en", 64'(sn[42]), 64'd0);
        chk("abort_busy", 64'(sn[0]), 64'd0);
        chk("abort_on", 64'(sn[43]), 64'd0);
        chk("abort_busy_last", 64'(bl), 64'd8);
        lcd_reg[31] = 1'b1;
        tick();
        tick();

        // Async reset in EXEC between edges, START high at release.
        lcd_reg[30] = ~lcd_reg[30];
        lcd_reg[9] = 1'b0;
        lcd_reg[7:0] = 8'h38;
        repeat (30) tick();
        chk("pre_reset_busy", 64'(lcd_status[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 64'(act_vec), 64'd0);
        lcd_reg = 32'hC000_0055;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("release_req_busy", 64'(lcd_status[0]), 64'd1);
        chk("release_req_data", 64'(lcd_data), 64'h55);
        begin
            bit done;
            done = 1'b0;
            for (int k = 0; k < 400; k++) begin
                tick();
                if (!lcd_status[0]) begin done = 1'b1; break; end
            end
            chk("release_txn_done", 64'(done), 64'd1);
        end
        run_txn(1'b1, 8'h41, -1, -1, -1, ef, el, bl, np, sn, d1, r1, to);
        chk("post_reset_busy_last", 64'(bl), 64'd56);
        chk("post_reset_rs", 64'(r1), 64'd1);
        chk("post_reset_data", 64'(d1), 64'h41);

        // Randomized phase, model compared every cycle.
        for (int k = 0; k < 4000; k++) begin
            tick();
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                lcd_reg[30] = ~lcd_reg[30];
                lcd_reg[9] = 1'($urandom_range(0, 1));
                lcd_reg[7:0] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            end else if (r == 4) begin
                lcd_reg[31] = ~lcd_reg[31];
            end else if (r < 15) begin
                lcd_reg[9] = 1'($urandom_range(0, 1));
                lcd_reg[7:0] = 8'($urandom);
                lcd_reg[29:10] = 20'($urandom);
                lcd_reg[8] = 1'($urandom_range(0, 1));
            end else if (r < 30 && !lcd_reg[31]) begin
                lcd_reg[31] = 1'b1;
            end
            if ((k % 1000) == 999) begin
                #2 rst_n = 1'b0;
                #1 chk("rand_async_reset", 64'(act_vec), 64'd0);
                #1 rst_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
